// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: issues IROM reads under a credit rule
// and buffers {pc, inst} pairs toward decode.
module inst_fetch_queue #(
  parameter int QDEPTH = 2,
  parameter int AW     = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   pc_i,
  output logic          pc_ready_o,
  output logic [AW-1:0] irom_addr_o,
  input  logic [31:0]   irom_inst_i,
  input  logic          flush_i,
  output logic          id_valid_o,
  input  logic          id_ready_i,
  output logic [31:0]   id_pc_o,
  output logic [31:0]   id_inst_o
);

  localparam int PW = $clog2(QDEPTH);
  localparam logic [PW+1:0] QD = (PW+2)'(QDEPTH);

  logic [PW:0]   occ;
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic          inflight;
  logic [31:0]   req_pc;
  logic [31:0]   pc_q   [QDEPTH];
  logic [31:0]   inst_q [QDEPTH];

  logic          nonempty;
  logic          pop;
  logic          push;
  logic          issue;
  logic [PW+1:0] credit;

  assign irom_addr_o = pc_i[AW+1:2];

  assign nonempty   = (occ != '0);
  assign id_valid_o = nonempty & ~flush_i;
  assign pop        = id_valid_o & id_ready_i;
  assign push       = inflight & ~flush_i;

  // Slots already committed: stored, returning next edge, minus the one leaving.
  assign credit = {1'b0, occ}
                + {{(PW+1){1'b0}}, inflight}
                - {{(PW+1){1'b0}}, pop};

  assign issue      = ~flush_i & (credit < QD);
  assign pc_ready_o = issue;

  assign id_pc_o   = nonempty ? pc_q[rptr]   : '0;
  assign id_inst_o = nonempty ? inst_q[rptr] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ      <= '0;
      rptr     <= '0;
      wptr     <= '0;
      inflight <= 1'b0;
      req_pc   <= '0;
    end else if (flush_i) begin
      occ      <= '0;
      rptr     <= '0;
      wptr     <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) req_pc <= pc_i;
      if (push)  wptr   <= wptr + PW'(1);
      if (pop)   rptr   <= rptr + PW'(1);
      occ <= occ
           + {{PW{1'b0}}, push}
           - {{PW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < QDEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else if (push) begin
      pc_q[wptr]   <= req_pc;
      inst_q[wptr] <= irom_inst_i;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with a queue-level
// reference model checked every cycle.
module tb_inst_fetch_queue;

  localparam int QDEPTH = 2;
  localparam int AW     = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   pc_i = '0;
  logic          pc_ready_o;
  logic [AW-1:0] irom_addr_o;
  logic [31:0]   irom_inst_i;
  logic          flush_i = 1'b0;
  logic          id_valid_o;
  logic          id_ready_i = 1'b0;
  logic [31:0]   id_pc_o;
  logic [31:0]   id_inst_o;

  inst_fetch_queue #(.QDEPTH(QDEPTH), .AW(AW)) dut (
    .clk(clk),
    .rst(rst),
    .pc_i(pc_i),
    .pc_ready_o(pc_ready_o),
    .irom_addr_o(irom_addr_o),
    .irom_inst_i(irom_inst_i),
    .flush_i(flush_i),
    .id_valid_o(id_valid_o),
    .id_ready_i(id_ready_i),
    .id_pc_o(id_pc_o),
    .id_inst_o(id_inst_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [13:0] a);
    return 32'hC0DE_0000 | {18'b0, a};
  endfunction

  // IROM: one-cycle read latency
  always @(posedge clk) irom_inst_i <= rom(irom_addr_o);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  bit          mf = 1'b0;
  logic [31:0] mpc = '0;

  function automatic bit m_valid();
    return (mq.size() != 0) && !flush_i;
  endfunction

  function automatic bit m_issue(input bit p);
    int used;
    used = mq.size() + int'(mf) - int'(p);
    return !flush_i && (used < QDEPTH);
  endfunction

  always @(posedge clk or negedge rst) begin : model
    bit p;
    bit is;
    if (!rst) begin
      mq.delete();
      mf  = 1'b0;
      mpc = '0;
    end else begin
      p  = m_valid() && id_ready_i;
      is = m_issue(p);
      if (flush_i) begin
        mq.delete();
        mf = 1'b0;
      end else begin
        if (p) void'(mq.pop_front());
        if (mf) mq.push_back('{mpc, rom(mpc[15:2])});
        mf = is;
        if (is) mpc = pc_i;
      end
    end
  end

  int          n_chk  = 0;
  int          n_fail = 0;
  bit          auto_pc = 1'b1;
  logic [31:0] acc_log[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h @%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] logat(input int i);
    return (i < acc_log.size()) ? acc_log[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic compare_all();
    bit          v;
    bit          p;
    bit          ovf;
    logic [31:0] epc;
    logic [31:0] ein;
    v   = m_valid();
    p   = v && id_ready_i;
    epc = (mq.size() != 0) ? mq[0].pc   : 32'h0;
    ein = (mq.size() != 0) ? mq[0].inst : 32'h0;
    chk("valid", 32'(id_valid_o), 32'(v));
    chk("id_pc", id_pc_o, epc);
    chk("id_inst", id_inst_o, ein);
    chk("pc_ready", 32'(pc_ready_o), 32'(m_issue(p)));
    chk("irom_addr", 32'(irom_addr_o), 32'(pc_i[15:2]));
    ovf = dut.inflight && !flush_i && (32'(dut.occ) == QDEPTH)
          && !(id_valid_o && id_ready_i);
    chk("no_push_into_full", 32'(ovf), 32'h0);
    if (id_valid_o && id_ready_i) acc_log.push_back(id_pc_o);
  endtask

  task automatic tick();
    bit adv;
    @(negedge clk);
    if (rst) compare_all();
    adv = pc_ready_o;
    @(posedge clk);
    #1;
    if (adv && auto_pc) pc_i = pc_i + 32'd4;
  endtask

  task automatic do_reset(input logic [31:0] p, input logic r);
    rst        = 1'b0;
    flush_i    = 1'b0;
    id_ready_i = r;
    pc_i       = p;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    acc_log.delete();
  endtask

  logic [15:0] pat;

  initial begin
    // Basic latency and in-order stream
    do_reset(32'h0, 1'b1);
    #1;
    chk("ready_after_rst", 32'(pc_ready_o), 32'h1);
    chk("lat_cyc0_valid", 32'(id_valid_o), 32'h0);
    tick();
    chk("lat_cyc1_valid", 32'(id_valid_o), 32'h0);
    tick();
    chk("lat_cyc2_valid", 32'(id_valid_o), 32'h1);
    chk("lat_cyc2_pc", id_pc_o, 32'h0);
    chk("lat_cyc2_inst", id_inst_o, 32'hC0DE_0000);
    repeat (4) tick();
    chk("basic_seq0", logat(0), 32'h0);
    chk("basic_seq1", logat(1), 32'h4);
    chk("basic_seq2", logat(2), 32'h8);

    // Backpressure fills the queue and stops issuing
    do_reset(32'h0, 1'b0);
    repeat (6) tick();
    chk("bp_occ", 32'(dut.occ), 32'd2);
    chk("bp_ready", 32'(pc_ready_o), 32'h0);
    chk("bp_head", id_pc_o, 32'h0);
    chk("bp_inst", id_inst_o, 32'hC0DE_0000);
    id_ready_i = 1'b1;
    repeat (6) tick();
    chk("bp_seq0", logat(0), 32'h0);
    chk("bp_seq1", logat(1), 32'h4);
    chk("bp_seq2", logat(2), 32'h8);
    chk("bp_seq3", logat(3), 32'hC);

    // Flush drops queued and in-flight entries
    do_reset(32'h10, 1'b0);
    repeat (4) tick();
    chk("fl_head", id_pc_o, 32'h10);
    id_ready_i = 1'b1;
    tick();
    flush_i = 1'b1;
    pc_i    = 32'h100;
    acc_log.delete();
    #1;
    chk("fl_valid_f0", 32'(id_valid_o), 32'h0);
    chk("fl_ready_f0", 32'(pc_ready_o), 32'h0);
    tick();
    flush_i = 1'b0;
    #1;
    chk("fl_valid_f1", 32'(id_valid_o), 32'h0);
    chk("fl_ready_f1", 32'(pc_ready_o), 32'h1);
    tick();
    tick();
    chk("fl_new_valid", 32'(id_valid_o), 32'h1);
    chk("fl_new_pc", id_pc_o, 32'h100);
    chk("fl_new_inst", id_inst_o, 32'hC0DE_0040);
    repeat (3) tick();
    chk("fl_seq0", logat(0), 32'h100);
    chk("fl_seq1", logat(1), 32'h104);

    // Irregular decode acceptance: push/pop overlap, pointer wrap
    do_reset(32'h40, 1'b0);
    pat = 16'b1011_0010_1110_1101;
    for (int i = 0; i < 16; i++) begin
      id_ready_i = pat[i];
      tick();
    end
    id_ready_i = 1'b1;
    repeat (6) tick();
    chk("st_count_ge8", 32'(acc_log.size() >= 8), 32'h1);
    for (int i = 0; i < acc_log.size(); i++)
      chk("st_order", acc_log[i], 32'h40 + 32'(4 * i));

    // Asynchronous reset pulse between edges with a full queue
    do_reset(32'h80, 1'b0);
    repeat (6) tick();
    chk("ar_occ_before", 32'(dut.occ), 32'd2);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_valid", 32'(id_valid_o), 32'h0);
    chk("ar_pc", id_pc_o, 32'h0);
    chk("ar_inst", id_inst_o, 32'h0);
    chk("ar_occ", 32'(dut.occ), 32'h0);
    pc_i       = 32'h200;
    id_ready_i = 1'b1;
    acc_log.delete();
    #1;
    rst = 1'b1;
    repeat (6) tick();
    chk("ar_first", logat(0), 32'h200);
    chk("ar_second", logat(1), 32'h204);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
